// File: rtl/stream_fork_pkg.sv
// Shared types and helpers for the dynamic multicast fork and its per-output lanes.
package stream_fork_pkg;

  typedef enum logic [1:0] {
    LANE_EMPTY   = 2'd0,
    LANE_PARTIAL = 2'd1,
    LANE_FULL    = 2'd2
  } lane_state_e;

  localparam int unsigned MAX_CNT_WIDTH = 64;

  function automatic int unsigned usage_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // True while a counter of the given width (zero-extended into cnt) is below its all-ones ceiling.
  function automatic logic sat_can_inc(input logic [MAX_CNT_WIDTH-1:0] cnt,
                                       input int unsigned width);
    logic [MAX_CNT_WIDTH-1:0] max_val;
    if (width >= MAX_CNT_WIDTH) max_val = '1;
    else                        max_val = (64'd1 << width) - 64'd1;
    return cnt < max_val;
  endfunction

endpackage

// File: rtl/stream_fork_lane.sv
// Single-output FIFO lane: registered occupancy, no fall-through, head forced to zero when empty.
module stream_fork_lane
  import stream_fork_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 push_i,
  input  logic [DATA_WIDTH-1:0]                data_i,
  input  logic                                 pop_i,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic                                 valid_o,
  output logic [usage_width(FIFO_DEPTH)-1:0]   usage_o,
  output lane_state_e                          state_o
);

  localparam int unsigned USAGE_W = usage_width(FIFO_DEPTH);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [USAGE_W-1:0] DEPTH_U  = USAGE_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [USAGE_W-1:0]    usage_q, usage_d;
  lane_state_e           state_q, state_d;
  logic                  do_push, do_pop;

  // Explicit wrap keeps non-power-of-two depths inside the storage array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign valid_o = (usage_q != '0);
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & valid_o & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   usage_d = usage_q + USAGE_W'(1);
        2'b01:   usage_d = usage_q - USAGE_W'(1);
        default: usage_d = usage_q;
      endcase
    end

    if (usage_d == '0)          state_d = LANE_EMPTY;
    else if (usage_d == DEPTH_U) state_d = LANE_FULL;
    else                        state_d = LANE_PARTIAL;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
      state_q  <= LANE_EMPTY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
      state_q  <= state_d;
    end
  end

  // NOTE: storage is deliberately not reset; data_o is gated by valid_o so stale entries never leak.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign usage_o = usage_q;
  assign state_o = state_q;

  assert property (@(posedge clk_i) disable iff (rst_i) push_i |-> (usage_q != DEPTH_U))
    else $error("stream_fork_lane: push into a full lane");

endmodule

// File: rtl/stream_fork_dynamic_fifo.sv
// Dynamic multicast fork: each accepted beat is written into the FIFO lane of every output named
// in its mask; lanes drain independently so one slow consumer only stalls once its lane is full.
module stream_fork_dynamic_fifo
  import stream_fork_pkg::*;
#(
  parameter int unsigned N_OUP      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [DATA_WIDTH-1:0]                      data_i,
  input  logic                                       valid_i,
  output logic                                       ready_o,
  input  logic [N_OUP-1:0]                           sel_i,
  input  logic                                       sel_valid_i,
  output logic                                       sel_ready_o,
  input  logic                                       flush_i,
  output logic [N_OUP*DATA_WIDTH-1:0]                data_o,
  output logic [N_OUP-1:0]                           valid_o,
  input  logic [N_OUP-1:0]                           ready_i,
  output logic [N_OUP*usage_width(FIFO_DEPTH)-1:0]   usage_o,
  output logic [CNT_WIDTH-1:0]                       drop_cnt_o
);

  localparam int unsigned USAGE_W = usage_width(FIFO_DEPTH);

  lane_state_e          lane_state [N_OUP];
  logic [N_OUP-1:0]     lane_full;
  logic [N_OUP-1:0]     push;
  logic                 space, accept, drop;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Fullness comes only from registered lane state, so ready_i never reaches ready_o; a pop frees
  // its slot one cycle later, which limits FIFO_DEPTH=1 to one beat every two cycles per lane.
  assign space       = &(~sel_i | ~lane_full);
  assign ready_o     = ~rst_i & sel_valid_i & space & ~flush_i;
  assign sel_ready_o = ~rst_i & valid_i & space & ~flush_i;
  assign accept      = valid_i & ready_o;
  assign push        = {N_OUP{accept}} & sel_i;
  assign drop        = accept & (sel_i == '0);

  for (genvar i = 0; i < N_OUP; i++) begin : g_lane
    stream_fork_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .data_i  (data_i),
      .pop_i   (ready_i[i]),
      .data_o  (data_o[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o (valid_o[i]),
      .usage_o (usage_o[i*USAGE_W +: USAGE_W]),
      .state_o (lane_state[i])
    );
    assign lane_full[i] = (lane_state[i] == LANE_FULL);
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && sat_can_inc(64'(drop_cnt_q), CNT_WIDTH)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
  end

  // Flush leaves the drop counter alone; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;

  assert property (@(posedge clk_i) (N_OUP >= 1) && (FIFO_DEPTH >= 1) && (CNT_WIDTH <= MAX_CNT_WIDTH))
    else $error("stream_fork_dynamic_fifo: illegal parameterisation");

  assert property (@(posedge clk_i) disable iff (rst_i) (valid_i && !ready_o) |=> $stable(data_i))
    else $error("stream_fork_dynamic_fifo: data_i changed while waiting for accept");

  assert property (@(posedge clk_i) disable iff (rst_i) (sel_valid_i && !sel_ready_o) |=> $stable(sel_i))
    else $error("stream_fork_dynamic_fifo: sel_i changed while waiting for accept");

endmodule

// File: tb/tb_stream_fork_dynamic_fifo.sv
// Scoreboard bench: instance A (depth 2, 4-bit drop counter) for directed cases, instance B
// (depth 3, 16-bit counter) for a long mixed-traffic run with pointer wrap.
module tb_stream_fork_dynamic_fifo;

  localparam int N       = 3;
  localparam int DW      = 8;
  localparam int UW      = 2;
  localparam int DEPTH_A = 2;
  localparam int DEPTH_B = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   data_i      [2];
  logic            valid_i     [2];
  logic            sel_valid_i [2];
  logic            flush_i     [2];
  logic [N-1:0]    sel_i       [2];
  logic [N-1:0]    ready_i     [2];
  logic [N-1:0]    valid_o     [2];
  logic            ready_o     [2];
  logic            sel_ready_o [2];
  logic [N*DW-1:0] data_o      [2];
  logic [N*UW-1:0] usage_o     [2];
  logic [3:0]      drop_a;
  logic [15:0]     drop_b;

  logic [DW-1:0]   sb_q [2*N][$];
  int              exp_drop [2];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  bit              rand_done;

  stream_fork_dynamic_fifo #(.N_OUP(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH_A), .CNT_WIDTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data_i[0]), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .sel_i(sel_i[0]), .sel_valid_i(sel_valid_i[0]), .sel_ready_o(sel_ready_o[0]),
    .flush_i(flush_i[0]), .data_o(data_o[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
    .usage_o(usage_o[0]), .drop_cnt_o(drop_a)
  );

  stream_fork_dynamic_fifo #(.N_OUP(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH_B), .CNT_WIDTH(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data_i[1]), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .sel_i(sel_i[1]), .sel_valid_i(sel_valid_i[1]), .sel_ready_o(sel_ready_o[1]),
    .flush_i(flush_i[1]), .data_o(data_o[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
    .usage_o(usage_o[1]), .drop_cnt_o(drop_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input int l,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d lane%0d actual=%0h required=%0h", name, k, l, act, exp);
    end
  endtask

  // Monitor: lane occupancy, valid and head data must match the scoreboard every cycle.
  always @(negedge clk) begin : monitor
    int q;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        q = k * N + i;
        check("usage", k, i, 64'(usage_o[k][i*UW +: UW]), 64'(sb_q[q].size()));
        if (sb_q[q].size() != 0) begin
          check("valid", k, i, 64'(valid_o[k][i]), 64'd1);
          check("data", k, i, 64'(data_o[k][i*DW +: DW]), 64'(sb_q[q][0]));
          if (valid_o[k][i] && ready_i[k][i] && !flush_i[k] && !rst) void'(sb_q[q].pop_front());
        end else begin
          check("idle valid", k, i, 64'(valid_o[k][i]), 64'd0);
          check("idle data", k, i, 64'(data_o[k][i*DW +: DW]), 64'd0);
        end
      end
      check("drop_cnt", k, 0, (k == 0) ? 64'(drop_a) : 64'(drop_b), 64'(exp_drop[k]));
    end
  end

  // Offer one beat until accepted; on accept record the expected lane contents and drop count.
  task automatic send(input int k, input logic [DW-1:0] d, input logic [N-1:0] s, output int acc_cyc);
    bit acc;
    int dmax;
    dmax = (k == 0) ? 15 : 65535;
    data_i[k] = d; sel_i[k] = s; valid_i[k] = 1'b1; sel_valid_i[k] = 1'b1;
    acc = 1'b0;
    acc_cyc = -1;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = ready_o[k];
      check("sel_ready", k, 0, 64'(sel_ready_o[k]), 64'(ready_o[k]));
      @(posedge clk); #1;
    end
    if (!acc) begin
      check("send timeout", k, 0, 64'd0, 64'd1);
    end else begin
      acc_cyc = cyc;
      for (int i = 0; i < N; i++) if (s[i]) sb_q[k*N+i].push_back(d);
      if (s == '0) exp_drop[k] = (exp_drop[k] >= dmax) ? dmax : exp_drop[k] + 1;
    end
    valid_i[k] = 1'b0; sel_valid_i[k] = 1'b0;
  endtask

  task automatic do_flush(input int k);
    flush_i[k] = 1'b1;
    @(negedge clk);
    check("flush ready_o", k, 0, 64'(ready_o[k]), 64'd0);
    check("flush sel_ready_o", k, 0, 64'(sel_ready_o[k]), 64'd0);
    @(posedge clk); #1;
    flush_i[k] = 1'b0;
    for (int i = 0; i < N; i++) sb_q[k*N+i].delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int c, rel, t0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_i[k] = '0; sel_i[k] = '1; valid_i[k] = 1'b1; sel_valid_i[k] = 1'b1;
      flush_i[k] = 1'b0; ready_i[k] = '1; exp_drop[k] = 0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst valid_o", k, 0, 64'(valid_o[k]), 64'd0);
      check("rst usage_o", k, 0, 64'(usage_o[k]), 64'd0);
      check("rst data_o", k, 0, 64'(data_o[k]), 64'd0);
      check("rst ready_o", k, 0, 64'(ready_o[k]), 64'd0);
      check("rst sel_ready_o", k, 0, 64'(sel_ready_o[k]), 64'd0);
      valid_i[k] = 1'b0; sel_valid_i[k] = 1'b0;
    end
    check("rst drop_a", 0, 0, 64'(drop_a), 64'd0);
    check("rst drop_b", 1, 0, 64'(drop_b), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(1);

    // Multicast to lanes 0 and 2, visible the cycle after accept for exactly one cycle.
    send(0, 8'hA5, 3'b101, c);
    check("mc valid_o", 0, 0, 64'(valid_o[0]), 64'b101);
    check("mc data lane0", 0, 0, 64'(data_o[0][0 +: DW]), 64'hA5);
    check("mc data lane2", 0, 2, 64'(data_o[0][2*DW +: DW]), 64'hA5);
    cycles(1);
    check("mc valid_o after pop", 0, 0, 64'(valid_o[0]), 64'b000);
    cycles(2);

    // Lane 1 stalled: third beat waits until lane 1 pops once, then is taken two cycles after release.
    ready_i[0] = 3'b101;
    send(0, 8'h11, 3'b111, c);
    send(0, 8'h22, 3'b111, c);
    check("bp back-to-back", 0, 0, 64'(cyc - c), 64'd0);
    fork
      send(0, 8'h33, 3'b111, c);
      begin
        @(negedge clk);
        check("bp lane1 full", 0, 1, 64'(usage_o[0][UW +: UW]), 64'd2);
        repeat (3) begin
          check("bp ready_o", 0, 1, 64'(ready_o[0]), 64'd0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        ready_i[0][1] = 1'b1;
        rel = cyc;
      end
    join
    check("bp accept cycle", 0, 1, 64'(c - rel), 64'd2);
    cycles(4);

    // Zero mask: consumed without push, counter saturates at 4'hF.
    send(0, 8'h5A, 3'b000, c);
    check("drop first", 0, 0, 64'(drop_a), 64'd1);
    check("drop no valid", 0, 0, 64'(valid_o[0]), 64'd0);
    for (int j = 0; j < 16; j++) send(0, 8'(j), 3'b000, c);
    check("drop saturated", 0, 0, 64'(drop_a), 64'hF);

    // Flush with a beat pending: nothing accepted, lanes empty next cycle, counter kept.
    ready_i[0] = 3'b000;
    send(0, 8'h44, 3'b011, c);
    send(0, 8'h55, 3'b110, c);
    data_i[0] = 8'h66; sel_i[0] = 3'b111; valid_i[0] = 1'b1; sel_valid_i[0] = 1'b1;
    do_flush(0);
    check("flush valid_o", 0, 0, 64'(valid_o[0]), 64'd0);
    check("flush usage_o", 0, 0, 64'(usage_o[0]), 64'd0);
    check("flush keeps drop", 0, 0, 64'(drop_a), 64'hF);
    ready_i[0] = 3'b111;
    t0 = cyc;
    send(0, 8'h66, 3'b111, c);
    check("post-flush accept", 0, 0, 64'(c - t0), 64'd1);
    cycles(3);

    // Long mixed traffic on the depth-3 instance against the scoreboard.
    rand_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 2000; j++) send(1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), c);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          ready_i[1] = 3'($urandom_range(0, 7));
        end
      end
    join
    ready_i[1] = '1;
    cycles(10);
    for (int i = 0; i < N; i++) check("rand drained", 1, i, 64'(sb_q[N+i].size()), 64'd0);

    // Asynchronous reset mid-stream with lane 1 full and a beat pending.
    ready_i[0] = 3'b101;
    send(0, 8'h77, 3'b111, c);
    send(0, 8'h88, 3'b111, c);
    data_i[0] = 8'h99; sel_i[0] = 3'b111; valid_i[0] = 1'b1; sel_valid_i[0] = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    for (int q = 0; q < 2*N; q++) sb_q[q].delete();
    exp_drop[0] = 0; exp_drop[1] = 0;
    #1;
    check("arst valid_o", 0, 0, 64'(valid_o[0]), 64'd0);
    check("arst ready_o", 0, 0, 64'(ready_o[0]), 64'd0);
    check("arst usage_o", 0, 0, 64'(usage_o[0]), 64'd0);
    check("arst drop_a", 0, 0, 64'(drop_a), 64'd0);
    check("arst drop_b", 1, 0, 64'(drop_b), 64'd0);
    valid_i[0] = 1'b0; sel_valid_i[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_i[0] = '1;
    t0 = cyc;
    send(0, 8'hC3, 3'b010, c);
    check("resume accept", 0, 0, 64'(c - t0), 64'd1);
    check("resume valid_o", 0, 0, 64'(valid_o[0]), 64'b010);
    cycles(5);
    for (int q = 0; q < 2*N; q++) check("leftover", q / N, q % N, 64'(sb_q[q].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
